// File: rtl/ahb_sram_slave_p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_sram_slave_p : pipelined AHB-Lite SRAM slave, byte lanes, wait states
// Revision 1.0
// ----------------------------------------------------------------------------
module ahb_sram_slave_p #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [1:0]            htrans,
  input  logic                  hmastlock,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int         BYTES      = DATA_WIDTH / 8;
  localparam int         BW         = $clog2(BYTES);
  localparam int         AW         = $clog2(MEM_DEPTH);
  localparam logic [2:0] c_MAX_SIZE = 3'(BW);
  localparam logic [3:0] c_WS_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  localparam state_t c_OK_NEXT = (WAIT_STATES > 0) ? S_WAIT : S_DATA;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [AW-1:0]         r_widx;
  logic [BYTES-1:0]      r_be;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_idle_like;
  logic                  w_accept;
  logic                  w_err;
  logic [31:0]           w_amask;
  logic [AW-1:0]         w_a_widx;
  logic [BYTES-1:0]      w_a_be;
  logic                  w_commit;
  logic                  w_fetch_rd;
  logic [AW-1:0]         w_fetch_widx;
  logic [DATA_WIDTH-1:0] w_fetch_data;
  logic                  w_unused;

  // Lanes are those sharing the aligned 2^size block with the address offset.
  function automatic logic [BYTES-1:0] f_lanes(input logic [2:0] size, input logic [BW-1:0] off);
    logic [BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < BYTES; i++)
      m[i] = ((i >> size) == (int'(off) >> size));
    return m;
  endfunction

  assign w_unused    = ^{hburst, hprot, hmastlock, htrans[0]};
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept    = w_idle_like && hsel && hready && htrans[1];
  assign w_amask     = (32'd1 << hsize) - 32'd1;
  assign w_err       = (|(haddr >> (BW + AW))) || (hsize > c_MAX_SIZE) || (|(haddr & w_amask));
  assign w_a_widx    = haddr[BW +: AW];
  assign w_a_be      = f_lanes(hsize, haddr[BW-1:0]);
  assign w_commit    = (r_state == S_DATA) && r_write;

  // Read data is captured on the edge that enters DATA, from either the live
  // address phase (zero-wait) or the registered one (end of WAIT).
  assign w_fetch_widx = (r_state == S_WAIT) ? r_widx : w_a_widx;
  assign w_fetch_rd   = ((r_state == S_WAIT) && (r_cnt == 4'd0) && !r_write) ||
                        (w_accept && !w_err && !hwrite && (c_OK_NEXT == S_DATA));

  always_comb begin
    w_fetch_data = r_mem[w_fetch_widx];
    for (int i = 0; i < BYTES; i++)
      if (w_commit && r_be[i] && (r_widx == w_fetch_widx))
        w_fetch_data[8*i +: 8] = hwdata[8*i +: 8];
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    hreadyout   = 1'b1;
    hresp       = 1'b0;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        hresp = (r_state == S_ERR2);
        if (w_accept) w_state_nxt = w_err ? S_ERR1 : c_OK_NEXT;
        else          w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (r_cnt == 4'd0) w_state_nxt = S_DATA;
      end
      S_ERR1: begin
        hreadyout   = 1'b0;
        hresp       = 1'b1;
        w_state_nxt = S_ERR2;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_cnt   <= 4'd0;
      r_widx  <= '0;
      r_be    <= '0;
      r_write <= 1'b0;
    end else begin
      if (w_accept) begin
        r_widx  <= w_a_widx;
        r_be    <= w_a_be;
        r_write <= hwrite;
      end
      if (w_accept && !w_err)                          r_cnt <= c_WS_LOAD;
      else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)          r_hrdata <= '0;
    else if (w_fetch_rd) r_hrdata <= w_fetch_data;
  end

  assign hrdata = r_hrdata;

  always_ff @(posedge hclk) begin
    if (w_commit)
      for (int i = 0; i < BYTES; i++)
        if (r_be[i]) r_mem[r_widx][8*i +: 8] <= hwdata[8*i +: 8];
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave_p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ahb_sram_slave_p : two slaves (0 and 3 wait states) on one AHB-Lite bus
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_ahb_sram_slave_p;

  localparam logic [1:0] c_IDL = 2'b00;
  localparam logic [1:0] c_BSY = 2'b01;
  localparam logic [1:0] c_NS  = 2'b10;
  localparam logic [1:0] c_SQ  = 2'b11;

  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [3:0]  waits;
    logic [31:0] rdata;
    logic [7:0]  row;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  logic        hmastlock = 1'b0;
  logic        hready_ovr = 1'b0;
  logic        tgt = 1'b0;
  logic [31:0] haddr = '0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [3:0]  hprot = '0;
  logic [1:0]  htrans = c_IDL;
  logic [31:0] hwdata = '0;
  logic        ro0, rs0, ro1, rs1;
  logic [31:0] rd0, rd1;
  logic        w_hready;

  vec_t        tbl [29];
  exp_t        sb [$];
  logic [31:0] last_rd [2];
  int          n_checks = 0;
  int          n_pass = 0;

  assign w_hready = hready_ovr ? 1'b0 : (tgt ? ro1 : ro0);

  always #5 hclk = ~hclk;

  ahb_sram_slave_p #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel & ~tgt), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock),
    .hready(w_hready), .hwdata(hwdata), .hreadyout(ro0), .hresp(rs0), .hrdata(rd0)
  );

  ahb_sram_slave_p #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel & tgt), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock),
    .hready(w_hready), .hwdata(hwdata), .hreadyout(ro1), .hresp(rs1), .hrdata(rd1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [31:0] wd, input logic er,
                              input logic [31:0] rdx);
    vec_t v;
    v.trans = tr; v.wr = wr; v.addr = a; v.size = sz;
    v.wdata = wd; v.err = er; v.rdata = rdx;
    return v;
  endfunction

  // Pipelined master: drives rows in order, pushes expectations on address
  // acceptance, pops and compares when the matching data phase completes.
  task automatic run_rows(input int first, input int last);
    int          idx, waits, cyc, ap_row;
    bit          ap_valid, acc, dp_valid;
    vec_t        ap;
    exp_t        ex;
    logic [31:0] dp_wdata, rd;
    logic        hr, rs;
    idx = first; waits = 0; cyc = 0; ap_row = 0;
    ap_valid = 0; acc = 0; dp_valid = 0; ap = '0; dp_wdata = '0;
    while ((idx <= last || ap_valid || dp_valid || acc) && cyc < 200) begin
      @(posedge hclk); #1; cyc++;
      if (acc) begin dp_valid = 1; waits = 0; hwdata = dp_wdata; end
      hr = w_hready;
      rs = tgt ? rs1 : rs0;
      rd = tgt ? rd1 : rd0;
      if (dp_valid) begin
        if (hr) begin
          ex = sb.pop_front();
          check($sformatf("row%0d_hresp", ex.row), {31'd0, rs}, {31'd0, ex.err});
          check($sformatf("row%0d_waits", ex.row), 32'(waits), 32'(ex.waits));
          if (ex.rd && !ex.err) last_rd[tgt] = ex.rdata;
          check($sformatf("row%0d_hrdata", ex.row), rd, last_rd[tgt]);
          dp_valid = 0;
        end else begin
          waits++;
          check($sformatf("row%0d_wait_hresp", sb[0].row), {31'd0, rs}, {31'd0, sb[0].err});
        end
      end
      if (!ap_valid && idx <= last) begin
        ap = tbl[idx]; ap_row = idx; idx++; ap_valid = 1;
      end
      if (ap_valid) begin
        hsel = 1'b1; htrans = ap.trans; haddr = ap.addr; hwrite = ap.wr; hsize = ap.size;
      end else begin
        hsel = 1'b0; htrans = c_IDL;
      end
      acc = hr && ap_valid;
      if (acc) begin
        ex.rd    = ap.trans[1] && !ap.wr;
        ex.err   = ap.trans[1] && ap.err;
        ex.waits = ex.err ? 4'd1 : (ap.trans[1] ? (tgt ? 4'd3 : 4'd0) : 4'd0);
        ex.rdata = ap.rdata;
        ex.row   = 8'(ap_row);
        sb.push_back(ex);
        dp_wdata = ap.wdata;
        ap_valid = 0;
      end
    end
    hsel = 1'b0; htrans = c_IDL;
    if (idx <= last || ap_valid || dp_valid || acc) begin
      n_checks++;
      $display("FAIL rows%0d_%0d_timeout: got busy after %0d cycles expected done", first, last, cyc);
    end
  endtask

  initial begin
    tbl[0]  = mk(c_NS,  1, 32'h010, 3'd2, 32'hDEADBEEF, 0, 32'h0);
    tbl[1]  = mk(c_NS,  0, 32'h010, 3'd2, 32'h0,        0, 32'hDEADBEEF);
    tbl[2]  = mk(c_NS,  1, 32'h020, 3'd2, 32'h11223344, 0, 32'h0);
    tbl[3]  = mk(c_NS,  1, 32'h021, 3'd0, 32'hFFFFAAFF, 0, 32'h0);
    tbl[4]  = mk(c_NS,  0, 32'h020, 3'd2, 32'h0,        0, 32'h1122AA44);
    tbl[5]  = mk(c_NS,  1, 32'h022, 3'd1, 32'hBEEF5555, 0, 32'h0);
    tbl[6]  = mk(c_NS,  0, 32'h020, 3'd2, 32'h0,        0, 32'hBEEFAA44);
    tbl[7]  = mk(c_NS,  0, 32'h400, 3'd2, 32'h0,        1, 32'h0);
    tbl[8]  = mk(c_NS,  1, 32'h012, 3'd2, 32'h0,        1, 32'h0);
    tbl[9]  = mk(c_NS,  0, 32'h008, 3'd3, 32'h0,        1, 32'h0);
    tbl[10] = mk(c_NS,  0, 32'h002, 3'd2, 32'h0,        1, 32'h0);
    tbl[11] = mk(c_NS,  0, 32'h010, 3'd2, 32'h0,        0, 32'hDEADBEEF);
    tbl[12] = mk(c_NS,  1, 32'h3FC, 3'd2, 32'hA5A50FF0, 0, 32'h0);
    tbl[13] = mk(c_NS,  0, 32'h3FC, 3'd2, 32'h0,        0, 32'hA5A50FF0);
    tbl[14] = mk(c_NS,  1, 32'h040, 3'd2, 32'h01010101, 0, 32'h0);
    tbl[15] = mk(c_SQ,  1, 32'h044, 3'd2, 32'h02020202, 0, 32'h0);
    tbl[16] = mk(c_SQ,  1, 32'h048, 3'd2, 32'h03030303, 0, 32'h0);
    tbl[17] = mk(c_SQ,  1, 32'h04C, 3'd2, 32'h04040404, 0, 32'h0);
    tbl[18] = mk(c_NS,  0, 32'h040, 3'd2, 32'h0,        0, 32'h01010101);
    tbl[19] = mk(c_SQ,  0, 32'h044, 3'd2, 32'h0,        0, 32'h02020202);
    tbl[20] = mk(c_BSY, 0, 32'h048, 3'd2, 32'h0,        0, 32'h0);
    tbl[21] = mk(c_SQ,  0, 32'h048, 3'd2, 32'h0,        0, 32'h03030303);
    tbl[22] = mk(c_SQ,  0, 32'h04C, 3'd2, 32'h0,        0, 32'h04040404);
    tbl[23] = mk(c_NS,  1, 32'h050, 3'd2, 32'h77665544, 0, 32'h0);
    tbl[24] = mk(c_NS,  0, 32'h050, 3'd2, 32'h0,        0, 32'h77665544);
    tbl[25] = mk(c_NS,  0, 32'h1000, 3'd2, 32'h0,       1, 32'h0);
    tbl[26] = mk(c_NS,  1, 32'h060, 3'd2, 32'h12345678, 0, 32'h0);
    tbl[27] = mk(c_NS,  0, 32'h060, 3'd2, 32'h0,        0, 32'h12345678);
    tbl[28] = mk(c_NS,  0, 32'h010, 3'd2, 32'h0,        0, 32'hDEADBEEF);
    last_rd[0] = '0;
    last_rd[1] = '0;

    repeat (2) @(posedge hclk);
    #1;
    check("rst_hreadyout0", {31'd0, ro0}, 32'd1);
    check("rst_hresp0",     {31'd0, rs0}, 32'd0);
    check("rst_hrdata0",    rd0, 32'd0);
    check("rst_hreadyout3", {31'd0, ro1}, 32'd1);
    check("rst_hrdata3",    rd1, 32'd0);
    hreset = 1'b0;

    tgt = 1'b0;
    run_rows(0, 13);
    tgt = 1'b1;
    run_rows(14, 26);

    // Reset in the middle of a write's wait states: the write must be lost.
    hsel = 1'b1; htrans = c_NS; haddr = 32'h060; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    check("ws3_enter_wait", {31'd0, ro1}, 32'd0);
    hsel = 1'b0; htrans = c_IDL; hwdata = 32'hCAFEF00D;
    @(posedge hclk); #1;
    hreset = 1'b1;
    #1;
    check("arst_hreadyout", {31'd0, ro1}, 32'd1);
    check("arst_hresp",     {31'd0, rs1}, 32'd0);
    check("arst_hrdata",    rd1, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    run_rows(27, 27);

    // Address phase held with hready low must never be sampled.
    @(posedge hclk); #1;
    tgt = 1'b0; hready_ovr = 1'b1;
    hsel = 1'b1; htrans = c_NS; haddr = 32'h010; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge hclk); #1;
      check($sformatf("hrdy_low%0d_hreadyout", c), {31'd0, ro0}, 32'd1);
      check($sformatf("hrdy_low%0d_hresp", c),     {31'd0, rs0}, 32'd0);
    end
    hsel = 1'b0; htrans = c_IDL; hready_ovr = 1'b0;
    run_rows(28, 28);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
